mac_dot_sequencer: RTL

//  Initiator/consumer for the fixed-point MAC: buffers operand-pair vectors and streams them into the MAC

---
 rtl/mac_dot_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mac_dot_sequencer.sv
// -----------------------------------------------------------------------------
// mac_dot_sequencer
//
// Front-end sequencer for one fixed-point MAC. Holds a small buffer of operand
// pairs and streams them into the MAC's input handshake. It then drains the
// MAC's per-beat accumulator outputs and returns the last one as the dot
// product. Every run starts with a one-cycle clear that the top level ORs into
// the MAC reset, so the accumulator always starts at zero.
//
// Ports
//   clk_i, reset_i             clock, asynchronous active-high reset
//   wr_valid_i/wr_ready_o      operand write handshake (addr, a, b)
//   wr_addr_i, wr_a_i, wr_b_i  buffer index and signed fixed-point operands
//   start_i, len_i             start a run of len_i beats (clamped to depth_p)
//   busy_o                     run in progress (CLEAR, RUN or DRAIN)
//   done_o, result_o           one-cycle completion pulse, held final result
//   mac_clear_o                one-cycle accumulator clear towards the MAC
//   mac_valid_o/mac_ready_i    operand stream into the MAC (mac_a_o, mac_b_o)
//   mac_valid_i/mac_ready_o    accumulator beats back from the MAC (mac_data_i)
//
// Assumes depth_p >= 2. The sequencer does no arithmetic on the data. The
// result is the MAC's last accumulator beat, passed through unchanged.
// -----------------------------------------------------------------------------
module mac_dot_sequencer #(
  parameter int int_in_p   = 1,
  parameter int frac_in_p  = 11,
  parameter int int_out_p  = 10,
  parameter int frac_out_p = 22,
  parameter int depth_p    = 16,
  localparam int w_lp      = int_in_p + frac_in_p,
  localparam int r_lp      = int_out_p + frac_out_p,
  localparam int len_w_lp  = $clog2(depth_p + 1),
  localparam int aw_lp     = $clog2(depth_p)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  // operand buffer write port
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [aw_lp-1:0]    wr_addr_i,
  input  logic [w_lp-1:0]     wr_a_i,
  input  logic [w_lp-1:0]     wr_b_i,
  // run control
  input  logic                start_i,
  input  logic [len_w_lp-1:0] len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [r_lp-1:0]     result_o,
  // MAC side
  output logic                mac_clear_o,
  output logic                mac_valid_o,
  input  logic                mac_ready_i,
  output logic [w_lp-1:0]     mac_a_o,
  output logic [w_lp-1:0]     mac_b_o,
  input  logic                mac_valid_i,
  output logic                mac_ready_o,
  input  logic [r_lp-1:0]     mac_data_i
);

  localparam logic [2:0] idle_s  = 3'd0;
  localparam logic [2:0] clear_s = 3'd1;
  localparam logic [2:0] run_s   = 3'd2;
  localparam logic [2:0] drain_s = 3'd3;
  localparam logic [2:0] done_s  = 3'd4;

  localparam logic [len_w_lp-1:0] one_lp       = len_w_lp'(1);
  localparam logic [len_w_lp-1:0] depth_len_lp = len_w_lp'(depth_p);

  logic [2:0]          state_q,    state_d;
  logic [len_w_lp-1:0] len_q,      len_d;
  logic [len_w_lp-1:0] issued_q,   issued_d;
  logic [len_w_lp-1:0] received_q, received_d;
  logic [r_lp-1:0]     result_q,   result_d;
  logic                done_q,     done_d;

  logic [w_lp-1:0] buf_a_q [depth_p];
  logic [w_lp-1:0] buf_b_q [depth_p];

  logic             wr_fire;
  logic             issue_fire;
  logic             beat_fire;
  logic [aw_lp-1:0] issue_idx;

  // ---------------------------------------------------------------------------
  // Status / handshake outputs decoded from the state register
  // ---------------------------------------------------------------------------
  assign wr_ready_o  = (state_q == idle_s) || (state_q == done_s);
  assign busy_o      = (state_q == clear_s) || (state_q == run_s) || (state_q == drain_s);
  assign mac_clear_o = (state_q == clear_s);
  assign mac_ready_o = (state_q == run_s) || (state_q == drain_s);
  assign mac_valid_o = (state_q == run_s) && (issued_q < len_q);
  assign done_o      = done_q;
  assign result_o    = result_q;

  // issued_q < len_q <= depth_p whenever the index is used, so the low bits
  // are always a legal buffer address.
  assign issue_idx = issued_q[aw_lp-1:0];

  // Operands are forced to zero when no pair is offered. This keeps the bus
  // quiet after reset, even though the buffer itself is not cleared.
  assign mac_a_o = mac_valid_o ? buf_a_q[issue_idx] : '0;
  assign mac_b_o = mac_valid_o ? buf_b_q[issue_idx] : '0;

  assign wr_fire    = wr_valid_i && wr_ready_o && (int'(wr_addr_i) < depth_p);
  assign issue_fire = mac_valid_o && mac_ready_i;
  assign beat_fire  = mac_valid_i && mac_ready_o;

  // ---------------------------------------------------------------------------
  // Operand buffer
  // ---------------------------------------------------------------------------
  // NOTE: storage arrays get no reset. Each entry is written before it is read,
  // and leaving out the reset lets the arrays map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      buf_a_q[wr_addr_i] <= wr_a_i;
      buf_b_q[wr_addr_i] <= wr_b_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q;
    received_d = received_q;
    result_d   = result_q;
    done_d     = 1'b0;

    case (state_q)
      idle_s, done_s: begin
        if (start_i) begin
          state_d    = clear_s;
          len_d      = (int'(len_i) > depth_p) ? depth_len_lp : len_i;
          issued_d   = '0;
          received_d = '0;
        end
      end

      clear_s: begin
        if (len_q == '0) begin
          // An empty vector completes with a zero result and never offers a pair.
          state_d  = done_s;
          result_d = '0;
          done_d   = 1'b1;
        end else begin
          state_d = run_s;
        end
      end

      run_s, drain_s: begin
        if (issue_fire) begin
          issued_d = issued_q + one_lp;
        end
        if (beat_fire) begin
          received_d = received_q + one_lp;
        end
        // Completing the last beat wins over the RUN->DRAIN step. This covers
        // the case where the final issue and the final beat share a cycle.
        if (beat_fire && (received_d == len_q)) begin
          state_d  = done_s;
          result_d = mac_data_i;
          done_d   = 1'b1;
        end else if ((state_q == run_s) && (issued_d == len_q)) begin
          state_d = drain_s;
        end
      end

      default: state_d = idle_s;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. All flops then
  // update together at the edge, whatever order the processes run in.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= idle_s;
      len_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

endmodule
